// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Data-side memory controller between the processor core and a single-port
// synchronous data RAM. Each core request produces exactly one RAM access,
// and the core gets a one-cycle acq pulse when that access completes.
//
// Handshake (request / acknowledge / release):
//   The core raises Mem_Ctrl[0] (read) or Mem_Ctrl[1] (write; wins if both
//   bits are set). The request, DAddress and Ddout are captured only in IDLE.
//   After WAIT_CYC+1 ACCESS cycles the controller pulses acq for one cycle
//   (DONE), then sits in RELEASE until Mem_Ctrl[1:0]==0 before accepting
//   anything new, so a request held past acq is never executed twice.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_n      in   synchronous reset, active-low
//   Mem_Ctrl   in   core request: [0] read, [1] write, [3:2] ignored
//   DAddress   in   core data address
//   Ddout      in   core write data
//   Ddin       out  read data to core (registered, held until next read)
//   acq        out  access-complete pulse (one cycle)
//   busy       out  high in every state except IDLE
//   ram_en     out  RAM enable (first ACCESS cycle only)
//   ram_we     out  RAM write enable (first ACCESS cycle, writes only)
//   ram_addr   out  RAM address (registered)
//   ram_wdata  out  RAM write data (registered)
//   ram_rdata  in   RAM read data, valid one cycle after the address
//   dbg_state  out  current FSM state (0 IDLE, 1 ACCESS, 2 DONE, 3 RELEASE)
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [3:0]        Mem_Ctrl,
    input  logic [ADDR_W-1:0] DAddress,
    input  logic [DATA_W-1:0] Ddout,
    output logic [DATA_W-1:0] Ddin,
    output logic              acq,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    // Counter must hold WAIT_CYC; never narrower than one bit.
    localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_wr;
    logic [DATA_W-1:0] r_ddin;
    logic              r_acq;
    logic              r_busy;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    logic w_req_wr;
    logic w_req_rd;
    logic w_req_none;
    logic w_unused_ctrl;

    assign w_req_wr      = Mem_Ctrl[1];
    assign w_req_rd      = Mem_Ctrl[0] & ~Mem_Ctrl[1];
    assign w_req_none    = (Mem_Ctrl[1:0] == 2'b00);
    // Upper request bits carry no meaning for this controller.
    assign w_unused_ctrl = ^Mem_Ctrl[3:2];

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_ddin      <= '0;
            r_acq       <= 1'b0;
            r_busy      <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            // Strobes are single-cycle; states below raise them when needed.
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_acq    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req_wr || w_req_rd) begin
                        r_ram_addr  <= DAddress;
                        r_ram_wdata <= Ddout;
                        r_is_wr     <= w_req_wr;
                        r_cnt       <= CNT_W'(WAIT_CYC);
                        // Enable is registered here so it lands on the first
                        // ACCESS cycle together with the captured address.
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= w_req_wr;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        // RAM data for the first-cycle address is valid by now.
                        if (!r_is_wr) begin
                            r_ddin <= ram_rdata;
                        end
                        r_acq   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_RELEASE;
                end

                S_RELEASE: begin
                    if (w_req_none) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Ddin      = r_ddin;
    assign acq       = r_acq;
    assign busy      = r_busy;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign dbg_state = r_state;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-side memory controller that sits directly downstream of the processor core.
- Consumes the core's Mem_Ctrl request, DAddress and Ddout.
- Drives a single-port synchronous data RAM, and returns read data on Ddin with a one-cycle acq pulse that releases the core's control unit.
- Enforces a request/acknowledge/release handshake so that each core request produces exactly one RAM access.

Parameters:
DATA_W, 8, data bus width (Ddout, Ddin, RAM data)
ADDR_W, 8, address width (DAddress, RAM address)
WAIT_CYC, 1, extra ACCESS cycles beyond the first; min 1 (covers the 1-cycle RAM read latency)

Ports:
CLK  in  1  system clock, rising edge
RST_n  in  1  synchronous reset, active-low
Mem_Ctrl  in  4  core request: bit0 read, bit1 write, bits[3:2] ignored
DAddress  in  ADDR_W  core data address
Ddout  in  DATA_W  core write data
Ddin  out  DATA_W  read data to core (registered)
acq  out  1  access-complete pulse to core
busy  out  1  high in any state other than IDLE
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address is presented

Behaviour:
- Single clock (CLK). Synchronous active-low reset (RST_n): sampled on the CLK edge; RST_n=0 forces the reset state on that edge.
- Reset state: state=IDLE, Ddin=0, acq=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wait counter=0. Reset overrides every state, including mid-ACCESS; an aborted write has ram_we=0 from the next cycle.
- Request decode: req_wr=Mem_Ctrl[1]; req_rd=Mem_Ctrl[0]&~Mem_Ctrl[1]. Write wins when both bits are set.
- States:
  - IDLE: if req_wr|req_rd, latch DAddress→ram_addr, Ddout→ram_wdata and the op type; load counter=WAIT_CYC; go to ACCESS. Otherwise stay.
  - ACCESS: lasts exactly WAIT_CYC+1 cycles.
    - ram_en=1 on the first ACCESS cycle only; ram_we=1 on the first cycle only, and only for writes.
    - Counter decrements each cycle; at counter==0 go to DONE.
    - For reads, Ddin<=ram_rdata on that exit edge.
  - DONE: acq=1 for exactly one cycle; go to RELEASE.
  - RELEASE: wait until Mem_Ctrl[1:0]==0, then go to IDLE. If Mem_Ctrl[1:0] is already 0 in DONE, RELEASE lasts 1 cycle.
- Latency: request sampled in cycle 0 → acq high in cycle WAIT_CYC+2. With the default, acq is in cycle 3. Identical for reads and writes.
- Ddin holds its value until the next completed read; writes never modify Ddin.
- Mem_Ctrl, DAddress and Ddout changes after the IDLE sample are ignored until the controller returns to IDLE.
- A request still held after acq is not re-executed; a new access needs Mem_Ctrl[1:0]=0 for ≥1 cycle first.
- Back-to-back minimum period per access is WAIT_CYC+4 cycles: IDLE + ACCESS + DONE + RELEASE.
- busy=1 in ACCESS, DONE and RELEASE.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold RST_n=0 for 2 cycles with Mem_Ctrl=4'b0001 → all outputs 0, no ram_en; release → read begins in the first cycle after release.
- Read, WAIT_CYC=1: RAM[0x2A]=0x5C, Mem_Ctrl=0001, DAddress=0x2A at cycle 0 → ram_en in cycle 1, ram_addr=0x2A; Ddin=0x5C and acq=1 in cycle 3 only; Ddin still 0x5C after the release.
- Write: Mem_Ctrl=0010, DAddress=0x10, Ddout=0xA7 → single ram_we pulse in cycle 1 with ram_addr=0x10, ram_wdata=0xA7; acq in cycle 3; Ddin unchanged; subsequent read of 0x10 returns 0xA7.
- Held request: keep Mem_Ctrl=0001 for 10 cycles → exactly one ram_en pulse and one acq; drop to 0 → IDLE the next cycle; reassert → second access.
- Conflict/ignore: Mem_Ctrl=0011 → treated as write; changing DAddress to 0xFF during ACCESS → ram_addr remains the original value.
- Reset mid-op: assert RST_n=0 in cycle 1 of a write with WAIT_CYC=3 → ram_we=0, no acq, state=IDLE on the next cycle.
